uart_rx_unit: RTL and testbench
===============================

# uart_rx_unit

Asynchronous serial receiver for 8N1 frames. It converts the SoC's UART transmit line into parallel bytes, with a one-cycle valid strobe per received character. It sits beside the SoC, in the simulation top and in any host-side link. The bit rate is set at run time by a clock-per-bit count input; the same count value is programmed into the peer transmitter (9 in the standard simulation setup).

## Interface
- No parameters.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bc`  in  16  bit-period control: one serial bit lasts `bc+1` clock cycles. Supported range is `bc` ≥ 3. The value is latched at start-bit detection.
- `rx`  in  1  serial input; idle high; asynchronous to `clk`.
- `ch_vld`  out  1  single-cycle pulse: `ch` holds a newly received byte.
- `ch`  out  8  last received byte, LSB = first data bit.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All following logic uses the synchronized signal `rxs`.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- State machine: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rxs`==0, latch `bc` into `bcl`, load counter = `bcl>>1`, go to START.
  - START: count down to 0 (mid-bit). If `rxs`==0 at mid-bit, load counter = `bcl` and bit index = 0, then go to DATA. If `rxs`==1, treat it as a glitch and return to IDLE with no output.
  - DATA: at each counter expiry, shift `rxs` into the shift register MSB-first-in, so the first bit ends up at bit 0. Reload counter = `bcl`. After the 8th sample, go to STOP.
  - STOP: at counter expiry (stop-bit mid), if `rxs`==1, load `ch` from the shift register, pulse `ch_vld`, and go to IDLE. If `rxs`==0 (framing error), discard the byte with no `ch_vld`, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`==1, then go to IDLE.
- Counter: 16 bits, down-counting; "expiry" means the cycle it equals 0.
- Samples are taken at mid-bit, so up to ±(bc/2) cycles of cumulative drift per frame is tolerated.
- Back-to-back frames with no idle time are received, because STOP returns to IDLE half a bit early.
- `bc` changes while a frame is in progress do not affect that frame.

## Timing
- Reset values: `ch_vld`=0, `ch`=8'h00, state=IDLE, synchronizer=1, counter=0, shift register=0.
- Let T be the first clock on which the raw `rx` is sampled low at the input. `rxs` goes low 2 cycles later, and IDLE detects the start bit at T+2.
- Data bit k (k=0..7) is sampled at T+2+(bcl>>1)+1+(k+1)(bcl+1), within ±1 cycle.
- `ch_vld` is high for exactly one cycle: the cycle after the stop-bit mid sample. `ch` updates on the same edge and holds until the next valid frame.
- Reset asserted mid-frame: all state returns immediately to reset values and no `ch_vld` is produced. After release, reception restarts at the next falling edge of `rx`.
- A low pulse on `rx` shorter than about (bc+1)/2 cycles produces no output.

## Test plan
- `bc`=9, drive frame 0x55 at 10 clocks/bit -> exactly one `ch_vld` pulse with `ch`=0x55, and no other pulses.
- `bc`=9, back-to-back frames 0x48 then 0x69 with zero idle between stop and start -> two pulses, `ch`=0x48 then `ch`=0x69, spaced 100 cycles apart.
- `bc`=9, `rx` low for 3 cycles then high -> no `ch_vld`, state back to IDLE. A following 0xA3 frame is received correctly.
- `bc`=9, frame 0x3C with stop bit driven 0 for 20 cycles, then high -> no `ch_vld`. The next frame 0x10 yields `ch`=0x10 (the simulation end-of-output marker).
- `bc`=15, frame 0xFF, then `bc`=3 with frame 0x01 -> `ch`=0xFF then `ch`=0x01.
- Assert `rst_n`=0 during data bit 4 of frame 0x81 -> `ch_vld`=0 and `ch`=0x00 immediately. After release, frame 0x7E is received with `ch`=0x7E.

Source files
------------

// File: rtl/uart_rx_if.sv
// Parallel side of the UART receiver: bit-period control, serial line in,
// received byte and its strobe out.
interface uart_rx_if;
  logic [15:0] bc;
  logic        rx;
  logic        ch_vld;
  logic [7:0]  ch;

  modport master (
    output bc,
    output rx,
    input  ch_vld,
    input  ch
  );

  modport slave (
    input  bc,
    input  rx,
    output ch_vld,
    output ch
  );
endinterface

// File: rtl/uart_rx_unit.sv
// 8N1 asynchronous serial receiver with a run-time bit period.
// One serial bit lasts bc+1 clocks; every bit is sampled at its middle.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle, waiting for a low level (start bit edge)
// START     | counting to the start-bit middle, rejects short glitches
// DATA      | sampling 8 data bits at bit middles, LSB first
// STOP      | sampling the stop bit; a high level delivers the byte
// WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx_unit (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rxs;
  logic [15:0] bcl;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        cnt_zero;

  assign cnt_zero = (cnt == 16'd0);

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rxs     <= rx_meta;
    end
  end

  // Frame state machine: mid-bit sampling with a down-counter, registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bcl        <= 16'd0;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      bus.ch     <= 8'h00;
      bus.ch_vld <= 1'b0;
    end else begin
      bus.ch_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            // bc is captured here so a change mid-frame cannot disturb this frame
            bcl   <= bus.bc;
            cnt   <= bus.bc >> 1;
            state <= START;
          end
        end

        START: begin
          if (!cnt_zero) begin
            cnt <= cnt - 16'd1;
          end else if (!rxs) begin
            cnt     <= bcl;
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            // line went back high before mid start bit: a glitch, not a frame
            state <= IDLE;
          end
        end

        DATA: begin
          if (!cnt_zero) begin
            cnt <= cnt - 16'd1;
          end else begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= bcl;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          if (!cnt_zero) begin
            cnt <= cnt - 16'd1;
          end else if (rxs) begin
            // leaving at mid stop bit leaves half a bit of slack for a
            // back-to-back start edge
            bus.ch     <= shreg;
            bus.ch_vld <= 1'b1;
            state      <= IDLE;
          end else begin
            state <= WAIT_HIGH;
          end
        end

        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Scoreboard bench for uart_rx_unit: expected bytes are queued when a frame
// is driven and popped when the receiver strobes ch_vld.
module tb_uart_rx_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   n_pulse;
  int   cyc;
  int   t_prev;
  int   t_last;
  logic [7:0] exp_q[$];

  uart_rx_if bus ();

  uart_rx_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every strobe is matched against the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && bus.ch_vld) begin
      n_pulse++;
      t_prev = t_last;
      t_last = cyc;
      if (exp_q.size() == 0) begin
        chk("extra_vld", {31'b0, bus.ch_vld}, 32'd0);
      end else begin
        chk("ch", {24'b0, bus.ch}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic hold(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int cpb,
                            input logic stop_v, input int stop_len);
    hold(1'b0, cpb);
    for (int i = 0; i < 8; i++) hold(d[i], cpb);
    hold(stop_v, stop_len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_pulse = 0;
    cyc     = 0;
    t_prev  = 0;
    t_last  = 0;
    bus.rx  = 1'b1;
    bus.bc  = 16'd9;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", {31'b0, bus.ch_vld}, 32'd0);
    chk("rst_ch", {24'b0, bus.ch}, 32'h00);
    rst_n = 1'b1;
    hold(1'b1, 5);

    // single frame
    exp_q.push_back(8'h55);
    send_frame(8'h55, 10, 1'b1, 10);
    hold(1'b1, 20);
    chk("pulses_55", n_pulse, 1);

    // back-to-back frames, no idle between stop and start
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    send_frame(8'h48, 10, 1'b1, 10);
    send_frame(8'h69, 10, 1'b1, 10);
    hold(1'b1, 20);
    chk("pulses_b2b", n_pulse, 3);
    chk("b2b_spacing", t_last - t_prev, 100);

    // short low glitch
    hold(1'b0, 3);
    hold(1'b1, 30);
    chk("pulses_glitch", n_pulse, 3);
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 10, 1'b1, 10);
    hold(1'b1, 20);
    chk("pulses_a3", n_pulse, 4);

    // framing error: stop bit low for 20 cycles
    send_frame(8'h3C, 10, 1'b0, 20);
    hold(1'b1, 30);
    chk("pulses_ferr", n_pulse, 4);
    exp_q.push_back(8'h10);
    send_frame(8'h10, 10, 1'b1, 10);
    hold(1'b1, 20);
    chk("pulses_10", n_pulse, 5);

    // slow rate, with bc changed mid-frame, then fastest rate
    bus.bc = 16'd15;
    exp_q.push_back(8'hFF);
    fork
      send_frame(8'hFF, 16, 1'b1, 16);
      begin
        repeat (50) @(posedge clk);
        #1;
        bus.bc = 16'd3;
      end
    join
    hold(1'b1, 30);
    chk("pulses_ff", n_pulse, 6);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 4, 1'b1, 4);
    hold(1'b1, 20);
    chk("pulses_01", n_pulse, 7);

    // reset during data bit 4 of 0x81
    bus.bc = 16'd9;
    hold(1'b1, 10);
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 10);
    hold(1'b0, 10);
    hold(1'b0, 10);
    hold(1'b0, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", {31'b0, bus.ch_vld}, 32'd0);
    chk("midrst_ch", {24'b0, bus.ch}, 32'h00);
    bus.rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 20);
    chk("pulses_rst", n_pulse, 7);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 10, 1'b1, 10);
    hold(1'b1, 20);
    chk("pulses_7e", n_pulse, 8);
    chk("ch_hold", {24'b0, bus.ch}, 32'h7E);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
